tx_lp_hs_sequencer: RTL and testbench

//  Parametrised successor to the D-PHY TX low-power FSM. Sequences the LP->HS->LP

---
 rtl/tx_lp_hs_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_tx_lp_hs_sequencer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/tx_lp_hs_sequencer.sv
// D-PHY TX LP->HS->LP sequencer with programmable per-phase timing for LANES lanes.
// Optional ULPS entry/exit is built when the TX_ULPS_EN macro is defined.
module tx_lp_hs_sequencer #(
    parameter int LANES = 1,
    parameter int CW    = 8
) (
    input  logic             TX_BYTE_clk,
    input  logic             TX_rst,
    input  logic             TX_REQ,
    input  logic             TX_ULPS_REQ,
    input  logic [CW-1:0]    cfg_t_lpx,
    input  logic [CW-1:0]    cfg_t_prep,
    input  logic [CW-1:0]    cfg_t_zero,
    input  logic [CW-1:0]    cfg_t_trail,
    input  logic [CW-1:0]    cfg_t_exit,
    output logic [LANES-1:0] Dp,
    output logic [LANES-1:0] Dn,
    output logic             TX_HS_EN,
    output logic             TX_READY_HS,
    output logic             TX_HS_END_DATA,
`ifdef TX_ULPS_EN
    output logic [3:0]       TX_LP_STATE
`else
    output logic [2:0]       TX_LP_STATE
`endif
);

`ifdef TX_ULPS_EN
    localparam int SW = 4;
`else
    localparam int SW = 3;
`endif

    typedef enum logic [SW-1:0] {
        ST_STOP      = SW'(0),
        ST_HS_RQST   = SW'(1),
        ST_HS_PRPR   = SW'(2),
        ST_HS_ZERO   = SW'(3),
        ST_HS_DATA   = SW'(4),
        ST_HS_TRAIL  = SW'(5),
        ST_HS_EXIT   = SW'(6)
`ifdef TX_ULPS_EN
        ,
        ST_ULPS_RQST = SW'(8),
        ST_ULPS      = SW'(9),
        ST_ULPS_WAKE = SW'(10)
`endif
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  prep_q, prep_d, zero_q, zero_d, trail_q, trail_d, exit_q, exit_d;
    logic           dp_q, dp_d, dn_q, dn_d, hs_en_q, hs_en_d, end_q, end_d;
    logic           phase_done;

`ifndef TX_ULPS_EN
    logic unused_ulps_req;
    assign unused_ulps_req = TX_ULPS_REQ;
`endif

    // A programmed length of 0 behaves like 1, so the counter starts at max(N,1)-1.
    function automatic logic [CW-1:0] load_cnt(input logic [CW-1:0] n);
        return (n == '0) ? '0 : n - 1'b1;
    endfunction

    assign phase_done = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = phase_done ? '0 : cnt_q - 1'b1;
        prep_d  = prep_q;
        zero_d  = zero_q;
        trail_d = trail_q;
        exit_d  = exit_q;
        case (state_q)
            ST_STOP: begin
                // Shadows track cfg while idle; the value at the leaving edge is kept.
                prep_d  = cfg_t_prep;
                zero_d  = cfg_t_zero;
                trail_d = cfg_t_trail;
                exit_d  = cfg_t_exit;
                cnt_d   = '0;
                if (TX_REQ) begin
                    state_d = ST_HS_RQST;
                    cnt_d   = load_cnt(cfg_t_lpx);
                end
`ifdef TX_ULPS_EN
                else if (TX_ULPS_REQ) begin
                    state_d = ST_ULPS_RQST;
                    cnt_d   = load_cnt(cfg_t_lpx);
                end
`endif
            end
            ST_HS_RQST: if (phase_done) begin
                state_d = ST_HS_PRPR;
                cnt_d   = load_cnt(prep_q);
            end
            ST_HS_PRPR: if (phase_done) begin
                state_d = ST_HS_ZERO;
                cnt_d   = load_cnt(zero_q);
            end
            ST_HS_ZERO: if (phase_done) begin
                if (TX_REQ) begin
                    state_d = ST_HS_DATA;
                end else begin
                    state_d = ST_HS_TRAIL;
                    cnt_d   = load_cnt(trail_q);
                end
            end
            ST_HS_DATA: if (!TX_REQ) begin
                state_d = ST_HS_TRAIL;
                cnt_d   = load_cnt(trail_q);
            end
            ST_HS_TRAIL: if (phase_done) begin
                state_d = ST_HS_EXIT;
                cnt_d   = load_cnt(exit_q);
            end
            ST_HS_EXIT: if (phase_done) begin
                state_d = ST_STOP;
            end
`ifdef TX_ULPS_EN
            ST_ULPS_RQST: if (phase_done) begin
                state_d = ST_ULPS;
            end
            ST_ULPS: if (!TX_ULPS_REQ) begin
                state_d = ST_ULPS_WAKE;
                cnt_d   = load_cnt(exit_q);
            end
            ST_ULPS_WAKE: if (phase_done) begin
                state_d = ST_STOP;
            end
`endif
            default: begin
                state_d = ST_STOP;
                cnt_d   = '0;
            end
        endcase
    end

    // Line levels are decoded from the next state so the registered outputs line up with state_q.
    always_comb begin
        dp_d    = 1'b1;
        dn_d    = 1'b1;
        hs_en_d = 1'b0;
        case (state_d)
            ST_HS_RQST: begin
                dp_d = 1'b0;
            end
            ST_HS_PRPR: begin
                dp_d = 1'b0;
                dn_d = 1'b0;
            end
            ST_HS_ZERO, ST_HS_DATA, ST_HS_TRAIL: begin
                dp_d    = 1'b0;
                dn_d    = 1'b0;
                hs_en_d = 1'b1;
            end
`ifdef TX_ULPS_EN
            ST_ULPS_RQST, ST_ULPS_WAKE: begin
                dn_d = 1'b0;
            end
            ST_ULPS: begin
                dp_d = 1'b0;
                dn_d = 1'b0;
            end
`endif
            default: begin
                dp_d = 1'b1;
                dn_d = 1'b1;
            end
        endcase
        end_d = (state_d == ST_HS_TRAIL) && (cnt_d == '0);
    end

    always_ff @(posedge TX_BYTE_clk) begin
        if (TX_rst) begin
            state_q <= ST_STOP;
            cnt_q   <= '0;
            prep_q  <= '0;
            zero_q  <= '0;
            trail_q <= '0;
            exit_q  <= '0;
            dp_q    <= 1'b1;
            dn_q    <= 1'b1;
            hs_en_q <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prep_q  <= prep_d;
            zero_q  <= zero_d;
            trail_q <= trail_d;
            exit_q  <= exit_d;
            dp_q    <= dp_d;
            dn_q    <= dn_d;
            hs_en_q <= hs_en_d;
            end_q   <= end_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign Dp[gi] = dp_q;
            assign Dn[gi] = dn_q;
        end
    endgenerate

    assign TX_HS_EN       = hs_en_q;
    assign TX_HS_END_DATA = end_q;
    assign TX_READY_HS    = (state_q == ST_HS_DATA) && TX_REQ;
    assign TX_LP_STATE    = state_q;

endmodule

// File: tb/tb_tx_lp_hs_sequencer.sv
// Directed testbench for tx_lp_hs_sequencer (default build, LANES=2).
module tb_tx_lp_hs_sequencer;
    localparam int LANES = 2;
    localparam int CW    = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             tx_req;
    logic             ulps_req;
    logic [CW-1:0]    t_lpx, t_prep, t_zero, t_trail, t_exit;
    logic [LANES-1:0] dp, dn;
    logic             hs_en, ready, end_data;
    logic [2:0]       lp_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tx_lp_hs_sequencer #(.LANES(LANES), .CW(CW)) dut (
        .TX_BYTE_clk    (clk),
        .TX_rst         (rst),
        .TX_REQ         (tx_req),
        .TX_ULPS_REQ    (ulps_req),
        .cfg_t_lpx      (t_lpx),
        .cfg_t_prep     (t_prep),
        .cfg_t_zero     (t_zero),
        .cfg_t_trail    (t_trail),
        .cfg_t_exit     (t_exit),
        .Dp             (dp),
        .Dn             (dn),
        .TX_HS_EN       (hs_en),
        .TX_READY_HS    (ready),
        .TX_HS_END_DATA (end_data),
        .TX_LP_STATE    (lp_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int st, input bit edp, input bit edn,
                            input bit ehs, input bit erdy, input bit eend);
        logic [LANES-1:0] xdp, xdn;
        xdp = {LANES{edp}};
        xdn = {LANES{edn}};
        cmp({tag, ".state"}, 32'(lp_state), st);
        cmp({tag, ".dp"},    32'(dp),       32'(xdp));
        cmp({tag, ".dn"},    32'(dn),       32'(xdn));
        cmp({tag, ".hs_en"}, 32'(hs_en),    32'(ehs));
        cmp({tag, ".ready"}, 32'(ready),    32'(erdy));
        cmp({tag, ".end"},   32'(end_data), 32'(eend));
        $display("t=%0t %s state=%0d dp=%b dn=%b hs=%b rdy=%b end=%b",
                 $time, tag, lp_state, dp, dn, hs_en, ready, end_data);
    endtask

    // n cycles in one phase; END_DATA is expected only on the final HS_TRAIL cycle.
    task automatic phase(input string tag, input int n, input int st, input bit edp,
                         input bit edn, input bit ehs, input bit erdy);
        for (int i = 0; i < n; i++) begin
            step();
            chk_outs($sformatf("%s[%0d]", tag, i), st, edp, edn, ehs, erdy, (st == 5) && (i == n - 1));
        end
    endtask

    initial begin
        rst = 1'b1; tx_req = 1'b0; ulps_req = 1'b0;
        t_lpx = 8'd2; t_prep = 8'd3; t_zero = 8'd4; t_trail = 8'd2; t_exit = 8'd3;

        // Reset held 3 cycles
        step(); step(); step();
        chk_outs("reset", 0, 1, 1, 0, 0, 0);
        rst = 1'b0;
        tx_req = 1'b1;
        chk_outs("pre_edge", 0, 1, 1, 0, 0, 0);

        // Full burst, 10 data cycles
        phase("b_rqst", 2, 1, 0, 1, 0, 0);
        phase("b_prpr", 3, 2, 0, 0, 0, 0);
        phase("b_zero", 4, 3, 0, 0, 1, 0);
        phase("b_data", 10, 4, 0, 0, 1, 1);
        tx_req = 1'b0;
        phase("b_trail", 2, 5, 0, 0, 1, 0);
        phase("b_exit", 3, 6, 1, 1, 0, 0);
        phase("b_stop", 1, 0, 1, 1, 0, 0);

        // Single-cycle TX_REQ pulse: no data phase
        tx_req = 1'b1;
        step();
        chk_outs("p_rqst[0]", 1, 0, 1, 0, 0, 0);
        tx_req = 1'b0;
        phase("p_rqst", 1, 1, 0, 1, 0, 0);
        phase("p_prpr", 3, 2, 0, 0, 0, 0);
        phase("p_zero", 4, 3, 0, 0, 1, 0);
        phase("p_trail", 2, 5, 0, 0, 1, 0);
        phase("p_exit", 3, 6, 1, 1, 0, 0);
        phase("p_stop", 2, 0, 1, 1, 0, 0);

        // All cfg zero: every timed phase lasts one cycle; re-request in TRAIL served from STOP
        t_lpx = 8'd0; t_prep = 8'd0; t_zero = 8'd0; t_trail = 8'd0; t_exit = 8'd0;
        tx_req = 1'b1;
        phase("z_rqst", 1, 1, 0, 1, 0, 0);
        phase("z_prpr", 1, 2, 0, 0, 0, 0);
        phase("z_zero", 1, 3, 0, 0, 1, 0);
        phase("z_data", 2, 4, 0, 0, 1, 1);
        tx_req = 1'b0;
        phase("z_trail", 1, 5, 0, 0, 1, 0);
        tx_req = 1'b1;
        phase("z_exit", 1, 6, 1, 1, 0, 0);
        phase("z_stop", 1, 0, 1, 1, 0, 0);
        phase("z2_rqst", 1, 1, 0, 1, 0, 0);
        tx_req = 1'b0;
        phase("z2_prpr", 1, 2, 0, 0, 0, 0);
        phase("z2_zero", 1, 3, 0, 0, 1, 0);
        phase("z2_trail", 1, 5, 0, 0, 1, 0);
        phase("z2_exit", 1, 6, 1, 1, 0, 0);
        phase("z2_stop", 2, 0, 1, 1, 0, 0);

        // cfg change mid-burst is ignored; reset during HS_DATA returns to STOP
        t_lpx = 8'd2; t_prep = 8'd3; t_zero = 8'd4; t_trail = 8'd2; t_exit = 8'd3;
        tx_req = 1'b1;
        phase("c_rqst", 2, 1, 0, 1, 0, 0);
        phase("c_prpr_a", 1, 2, 0, 0, 0, 0);
        t_zero = 8'd9;
        phase("c_prpr_b", 2, 2, 0, 0, 0, 0);
        phase("c_zero", 4, 3, 0, 0, 1, 0);
        phase("c_data", 1, 4, 0, 0, 1, 1);
        rst = 1'b1;
        phase("c_rst", 1, 0, 1, 1, 0, 0);
        rst = 1'b0;
        tx_req = 1'b0;
        phase("c_stop", 2, 0, 1, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
